// File: rtl/jpeg_stream_parser.sv
// ---------------------------------------------------------------------------
// jpeg_stream_parser
//
// Purpose: walks a baseline JPEG byte stream, tracks frame boundaries,
// latches the SOF0 picture dimensions and delivers the unstuffed
// entropy-coded-segment (ECS) bytes. Bytes are accepted only on cycles with
// data_valid=1; idle gaps of any length are allowed in every state.
//
// Ports:
//   clk           single clock
//   rstn          asynchronous active-low reset
//   data_valid    qualifies data_in
//   data_in       JPEG byte stream
//   ecs_valid     qualifies ecs_data (one cycle after the accepted byte)
//   ecs_data      unstuffed ECS byte
//   frame_start   pulse on SOI
//   frame_done    pulse on EOI
//   sof_ok        pulse when the SOF0 dimensions are latched
//   pic_width     SOF0 X, latched
//   pic_height    SOF0 Y, latched
//   err_sync      pulse on a protocol violation
//   ecs_byte_cnt  ECS bytes emitted in the current frame (saturating)
//
// Configuration: define JPEG_PARSE_CNT_EN to build the ECS byte counter;
// without it ecs_byte_cnt is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module jpeg_stream_parser #(
    parameter int W_CNT = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    output logic             ecs_valid,
    output logic [7:0]       ecs_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic             sof_ok,
    output logic [15:0]      pic_width,
    output logic [15:0]      pic_height,
    output logic             err_sync,
    output logic [W_CNT-1:0] ecs_byte_cnt
);

    // S_MEXP is the "marker expected" state entered after SOI and after
    // every ordinary segment: only an FF may follow there.
    localparam logic [2:0] S_HUNT   = 3'd0;
    localparam logic [2:0] S_MEXP   = 3'd1;
    localparam logic [2:0] S_MARK   = 3'd2;
    localparam logic [2:0] S_LEN_HI = 3'd3;
    localparam logic [2:0] S_LEN_LO = 3'd4;
    localparam logic [2:0] S_SEG    = 3'd5;
    localparam logic [2:0] S_ECS    = 3'd6;
    localparam logic [2:0] S_ECS_FF = 3'd7;

    logic [2:0]  state, state_nxt;
    logic        armed, armed_nxt;
    logic [7:0]  marker, marker_nxt;
    logic [7:0]  len_hi, len_hi_nxt;
    logic [15:0] seg_cnt, seg_cnt_nxt;
    logic [2:0]  seg_pos, seg_pos_nxt;
    logic        sof_short, sof_short_nxt;
    logic [15:0] h_tmp, w_tmp, h_new, w_new;
    logic [15:0] len_val;
    logic        fs_nxt, fd_nxt, err_nxt, emit_nxt, latch_nxt, seg_end;
    logic [7:0]  emit_byte;

    assign len_val = {len_hi, data_in};

    // SOF0 body offsets 1-2 carry the height and 3-4 the width, MSB first.
    // The current byte is folded in so the last body byte can be latched
    // in the same cycle it arrives.
    always_comb begin
        h_new = h_tmp;
        w_new = w_tmp;
        if (data_valid && state == S_SEG) begin
            case (seg_pos)
                3'd1:    h_new[15:8] = data_in;
                3'd2:    h_new[7:0]  = data_in;
                3'd3:    w_new[15:8] = data_in;
                3'd4:    w_new[7:0]  = data_in;
                default: ;
            endcase
        end
    end

    // Next-state and pulse decode. MARK and ECS_FF share the marker
    // handling; ECS_FF additionally recognises stuffing (00) and RSTn.
    always_comb begin
        state_nxt     = state;
        armed_nxt     = armed;
        marker_nxt    = marker;
        len_hi_nxt    = len_hi;
        seg_cnt_nxt   = seg_cnt;
        seg_pos_nxt   = seg_pos;
        sof_short_nxt = sof_short;
        fs_nxt        = 1'b0;
        fd_nxt        = 1'b0;
        err_nxt       = 1'b0;
        emit_nxt      = 1'b0;
        emit_byte     = data_in;
        latch_nxt     = 1'b0;
        seg_end       = 1'b0;
        if (data_valid) begin
            case (state)
                S_HUNT: begin
                    if (data_in == 8'hFF) begin
                        armed_nxt = 1'b1;
                    end else if (armed && data_in == 8'hD8) begin
                        fs_nxt    = 1'b1;
                        armed_nxt = 1'b0;
                        state_nxt = S_MEXP;
                    end else begin
                        armed_nxt = 1'b0;
                    end
                end
                S_MEXP: begin
                    if (data_in == 8'hFF) begin
                        state_nxt = S_MARK;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HUNT;
                    end
                end
                S_MARK, S_ECS_FF: begin
                    if (state == S_ECS_FF && data_in == 8'h00) begin
                        emit_nxt  = 1'b1;
                        emit_byte = 8'hFF;
                        state_nxt = S_ECS;
                    end else if (state == S_ECS_FF && data_in[7:3] == 5'b11010) begin
                        state_nxt = S_ECS;
                    end else if (data_in == 8'hFF) begin
                        state_nxt = state;
                    end else if (data_in == 8'hD9) begin
                        fd_nxt    = 1'b1;
                        state_nxt = S_HUNT;
                    end else if (data_in == 8'hD8) begin
                        err_nxt   = 1'b1;
                        fs_nxt    = 1'b1;
                        state_nxt = S_MEXP;
                    end else begin
                        marker_nxt = data_in;
                        state_nxt  = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    len_hi_nxt = data_in;
                    state_nxt  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (len_val < 16'd2) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HUNT;
                    end else begin
                        sof_short_nxt = (len_val < 16'd7);
                        seg_pos_nxt   = 3'd0;
                        seg_cnt_nxt   = len_val - 16'd2;
                        if (len_val == 16'd2) begin
                            seg_end = 1'b1;
                        end else begin
                            state_nxt = S_SEG;
                        end
                    end
                end
                S_SEG: begin
                    if (seg_pos != 3'd7) begin
                        seg_pos_nxt = seg_pos + 3'd1;
                    end
                    seg_cnt_nxt = seg_cnt - 16'd1;
                    if (seg_cnt == 16'd1) begin
                        seg_end = 1'b1;
                    end
                end
                S_ECS: begin
                    if (data_in == 8'hFF) begin
                        state_nxt = S_ECS_FF;
                    end else begin
                        emit_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_HUNT;
            endcase

            // A too-short SOF0 cannot hold both dimensions, so it flags an
            // error and leaves the previously latched picture size alone.
            if (seg_end) begin
                state_nxt = (marker == 8'hDA) ? S_ECS : S_MEXP;
                if (marker == 8'hC0) begin
                    if (sof_short_nxt) begin
                        err_nxt = 1'b1;
                    end else begin
                        latch_nxt = 1'b1;
                    end
                end
            end
        end
    end

    // Parser state plus registered outputs; every pulse and ecs_valid
    // appears exactly one cycle after the byte that caused it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_HUNT;
            armed       <= 1'b0;
            marker      <= 8'h00;
            len_hi      <= 8'h00;
            seg_cnt     <= 16'h0000;
            seg_pos     <= 3'd0;
            sof_short   <= 1'b0;
            h_tmp       <= 16'h0000;
            w_tmp       <= 16'h0000;
            pic_width   <= 16'h0000;
            pic_height  <= 16'h0000;
            ecs_valid   <= 1'b0;
            ecs_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            sof_ok      <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            state       <= state_nxt;
            armed       <= armed_nxt;
            marker      <= marker_nxt;
            len_hi      <= len_hi_nxt;
            seg_cnt     <= seg_cnt_nxt;
            seg_pos     <= seg_pos_nxt;
            sof_short   <= sof_short_nxt;
            h_tmp       <= h_new;
            w_tmp       <= w_new;
            ecs_valid   <= emit_nxt;
            ecs_data    <= emit_nxt ? emit_byte : 8'h00;
            frame_start <= fs_nxt;
            frame_done  <= fd_nxt;
            sof_ok      <= latch_nxt;
            err_sync    <= err_nxt;
            if (latch_nxt) begin
                pic_width  <= w_new;
                pic_height <= h_new;
            end
        end
    end

`ifdef JPEG_PARSE_CNT_EN
    // ECS byte counter: cleared on every SOI (including a restart),
    // sticks at all-ones instead of wrapping.
    logic [W_CNT-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (fs_nxt) begin
            cnt_q <= '0;
        end else if (emit_nxt && cnt_q != {W_CNT{1'b1}}) begin
            cnt_q <= cnt_q + {{(W_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign ecs_byte_cnt = cnt_q;
`else
    assign ecs_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_jpeg_stream_parser.sv
// ---------------------------------------------------------------------------
// tb_jpeg_stream_parser
//
// Self-checking bench for jpeg_stream_parser. Directed streams cover the
// reference frame, valid gaps, sync errors, short segments and a mid-frame
// reset; randomly generated well-formed frames are then checked against the
// expectations recorded while the frame was built (payload bytes, pulse
// counts, dimensions). A second instance with a 2-bit counter exercises
// counter saturation.
// ---------------------------------------------------------------------------
module tb_jpeg_stream_parser;

    localparam int W_CNT = 24;
`ifdef JPEG_PARSE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             data_valid = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic             ecs_valid;
    logic [7:0]       ecs_data;
    logic             frame_start, frame_done, sof_ok, err_sync;
    logic [15:0]      pic_width, pic_height;
    logic [W_CNT-1:0] ecs_byte_cnt;

    logic             s_ecs_valid;
    logic [7:0]       s_ecs_data;
    logic             s_frame_start, s_frame_done, s_sof_ok, s_err_sync;
    logic [15:0]      s_pic_width, s_pic_height;
    logic [1:0]       s_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int fs_cnt = 0, fd_cnt = 0, sof_cnt = 0, err_cnt = 0;
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    byte unsigned stim_q[$];

    always #5 clk = ~clk;

    jpeg_stream_parser #(.W_CNT(W_CNT)) dut (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .data_in(data_in),
        .ecs_valid(ecs_valid), .ecs_data(ecs_data),
        .frame_start(frame_start), .frame_done(frame_done), .sof_ok(sof_ok),
        .pic_width(pic_width), .pic_height(pic_height),
        .err_sync(err_sync), .ecs_byte_cnt(ecs_byte_cnt)
    );

    jpeg_stream_parser #(.W_CNT(2)) dut_small (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .data_in(data_in),
        .ecs_valid(s_ecs_valid), .ecs_data(s_ecs_data),
        .frame_start(s_frame_start), .frame_done(s_frame_done), .sof_ok(s_sof_ok),
        .pic_width(s_pic_width), .pic_height(s_pic_height),
        .err_sync(s_err_sync), .ecs_byte_cnt(s_cnt)
    );

    // Observe outputs on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (ecs_valid)   got_q.push_back(ecs_data);
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
        if (sof_ok)      sof_cnt++;
        if (err_sync)    err_cnt++;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected counter value for n emitted bytes with a w-bit counter.
    function automatic logic [31:0] exp_cnt(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return CNT_ON ? ((n > mx) ? mx : n) : 0;
    endfunction

    // Drive one accepted byte; inputs change #1 after the rising edge.
    task automatic applyStimulus(input byte unsigned b);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: back-to-back, mode 1: valid pattern 1-0-0-1, mode 2: random gaps
    task automatic send_stream(input int mode);
        foreach (stim_q[i]) begin
            applyStimulus(stim_q[i]);
            if (mode == 1)      idle(2);
            else if (mode == 2) idle($urandom_range(0, 3));
        end
        stim_q.delete();
        idle(3);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        fs_cnt = 0; fd_cnt = 0; sof_cnt = 0; err_cnt = 0;
    endtask

    task automatic compare_ecs(input string pfx);
        checkOutput({pfx, "_ecs_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput($sformatf("%s_ecs[%0d]", pfx, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string pfx);
        checkOutput({pfx, "_ecs_valid"}, ecs_valid, 0);
        checkOutput({pfx, "_ecs_data"}, ecs_data, 0);
        checkOutput({pfx, "_frame_start"}, frame_start, 0);
        checkOutput({pfx, "_frame_done"}, frame_done, 0);
        checkOutput({pfx, "_sof_ok"}, sof_ok, 0);
        checkOutput({pfx, "_err_sync"}, err_sync, 0);
        checkOutput({pfx, "_pic_width"}, pic_width, 0);
        checkOutput({pfx, "_pic_height"}, pic_height, 0);
        checkOutput({pfx, "_ecs_cnt"}, ecs_byte_cnt, 0);
        checkOutput({pfx, "_small_cnt"}, s_cnt, 0);
    endtask

    // Reference frame: 320x240 SOF0, empty SOS, payload 12 FF 34.
    task automatic run_frame1(input int mode, input string pfx);
        clear_obs();
        stim_q = {8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h0B, 8'h08, 8'h00, 8'hF0,
                  8'h01, 8'h40, 8'h01, 8'h01, 8'h11, 8'h00,
                  8'hFF, 8'hDA, 8'h00, 8'h02,
                  8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF};
        exp_q  = {8'h12, 8'hFF, 8'h34};
        send_stream(mode);
        applyStimulus(8'hD9);
        checkOutput({pfx, "_fd_latency"}, frame_done, 1);
        idle(3);
        checkOutput({pfx, "_fs_cnt"}, fs_cnt, 1);
        checkOutput({pfx, "_sof_cnt"}, sof_cnt, 1);
        checkOutput({pfx, "_fd_cnt"}, fd_cnt, 1);
        checkOutput({pfx, "_err_cnt"}, err_cnt, 0);
        checkOutput({pfx, "_pic_height"}, pic_height, 240);
        checkOutput({pfx, "_pic_width"}, pic_width, 320);
        checkOutput({pfx, "_ecs_cnt"}, ecs_byte_cnt, exp_cnt(3, W_CNT));
        checkOutput({pfx, "_small_cnt"}, s_cnt, exp_cnt(3, 2));
        compare_ecs(pfx);
    endtask

    // Builds one well-formed frame into stim_q and records the expected
    // payload in exp_q together with the dimensions it carries.
    task automatic gen_random_frame(output int n_ecs, output logic [15:0] w, output logic [15:0] h);
        int           n, len, k;
        byte unsigned b;
        n = $urandom_range(0, 4);
        repeat (n) begin
            b = 8'($urandom);
            if (b == 8'hD8) b = 8'h00;
            stim_q.push_back(b);
        end
        stim_q = {stim_q, 8'hFF, 8'hD8};
        n = $urandom_range(0, 2);
        repeat (n) begin
            repeat ($urandom_range(0, 2)) stim_q.push_back(8'hFF);
            len = $urandom_range(2, 8);
            stim_q = {stim_q, 8'hFF, 8'(8'hE0 + $urandom_range(0, 15)), 8'h00, 8'(len)};
            repeat (len - 2) stim_q.push_back(8'($urandom));
        end
        w = 16'($urandom);
        h = 16'($urandom);
        k = $urandom_range(0, 3);
        stim_q = {stim_q, 8'hFF, 8'hC0, 8'h00, 8'(7 + k), 8'h08, h[15:8], h[7:0], w[15:8], w[7:0]};
        repeat (k) stim_q.push_back(8'($urandom));
        len = $urandom_range(2, 5);
        stim_q = {stim_q, 8'hFF, 8'hDA, 8'h00, 8'(len)};
        repeat (len - 2) stim_q.push_back(8'($urandom));
        n_ecs = $urandom_range(1, 24);
        for (int i = 0; i < n_ecs; i++) begin
            if ($urandom_range(0, 5) == 0)
                stim_q = {stim_q, 8'hFF, 8'(8'hD0 + $urandom_range(0, 7))};
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            exp_q.push_back(b);
            if (b == 8'hFF) begin
                if ($urandom_range(0, 1) == 1) stim_q.push_back(8'hFF);
                stim_q = {stim_q, 8'hFF, 8'h00};
            end else begin
                stim_q.push_back(b);
            end
        end
        stim_q = {stim_q, 8'hFF, 8'hD9};
    endtask

    // Main sequence: reset, directed cases, random frames, mid-frame reset.
    initial begin
        int          n_ecs;
        logic [15:0] rw, rh;

        #1 rstn = 1'b0;
        #3;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        run_frame1(0, "f1");
        run_frame1(1, "f1gap");

        // SOF0 whose length cannot hold both dimensions
        clear_obs();
        stim_q = {8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h05, 8'h08, 8'h00, 8'hF0, 8'hFF, 8'hD9};
        send_stream(0);
        checkOutput("sofshort_err", err_cnt, 1);
        checkOutput("sofshort_sof", sof_cnt, 0);
        checkOutput("sofshort_w", pic_width, 320);
        checkOutput("sofshort_h", pic_height, 240);
        checkOutput("sofshort_fd", fd_cnt, 1);

        // Non-FF after SOI, then the parser must resynchronise on FF D8
        clear_obs();
        stim_q = {8'hFF, 8'hD8, 8'h55};
        send_stream(0);
        checkOutput("sync_err", err_cnt, 1);
        checkOutput("sync_fs", fs_cnt, 1);
        clear_obs();
        stim_q = {8'h12, 8'hFF, 8'hD8, 8'hFF, 8'hD9};
        send_stream(0);
        checkOutput("resync_fs", fs_cnt, 1);
        checkOutput("resync_err", err_cnt, 0);
        checkOutput("resync_fd", fd_cnt, 1);

        // Length below 2
        clear_obs();
        stim_q = {8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h01};
        send_stream(0);
        checkOutput("lenlt2_err", err_cnt, 1);
        checkOutput("lenlt2_sof", sof_cnt, 0);

        for (int f = 0; f < 25; f++) begin
            clear_obs();
            gen_random_frame(n_ecs, rw, rh);
            send_stream(2);
            checkOutput($sformatf("rnd%0d_fs", f), fs_cnt, 1);
            checkOutput($sformatf("rnd%0d_fd", f), fd_cnt, 1);
            checkOutput($sformatf("rnd%0d_sof", f), sof_cnt, 1);
            checkOutput($sformatf("rnd%0d_err", f), err_cnt, 0);
            checkOutput($sformatf("rnd%0d_w", f), pic_width, rw);
            checkOutput($sformatf("rnd%0d_h", f), pic_height, rh);
            checkOutput($sformatf("rnd%0d_cnt", f), ecs_byte_cnt, exp_cnt(n_ecs, W_CNT));
            checkOutput($sformatf("rnd%0d_scnt", f), s_cnt, exp_cnt(n_ecs, 2));
            compare_ecs($sformatf("rnd%0d", f));
        end

        // Reset for one cycle while inside the ECS
        stim_q = {8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_stream(0);
        rstn = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_obs();
        stim_q = {8'hFF, 8'hD9, 8'h77};
        send_stream(0);
        checkOutput("rst_mid_no_fd", fd_cnt, 0);
        checkOutput("rst_mid_no_ecs", got_q.size(), 0);
        run_frame1(2, "f_postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/jpeg_stream_parser.md
JPEG_STREAM_PARSER -- requirements
Module: jpeg_stream_parser

Interface
REQ-001 SHALL have parameter W_CNT, default 24, width of the ECS byte counter.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_valid  input  1  qualifies data_in for one cycle.
REQ-005 SHALL have port data_in  input  8  JPEG byte stream, same format as the encoder output.
REQ-006 SHALL have port ecs_valid  output  1  qualifies ecs_data.
REQ-007 SHALL have port ecs_data  output  8  unstuffed entropy-coded-segment byte.
REQ-008 SHALL have port frame_start  output  1  one-cycle pulse on SOI.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse on EOI.
REQ-010 SHALL have port sof_ok  output  1  one-cycle pulse when SOF0 dimensions are latched.
REQ-011 SHALL have ports pic_width and pic_height  output  16 each  latched from SOF0 X and Y.
REQ-012 SHALL have port err_sync  output  1  one-cycle pulse on a protocol violation.
REQ-013 SHALL have port ecs_byte_cnt  output  W_CNT  count of ECS bytes in the current frame.

Function
REQ-014 SHALL advance state and counters only on cycles with data_valid=1; gaps of any length SHALL be legal in every state.
REQ-015 SHALL implement the states HUNT, MARK, LEN_HI, LEN_LO, SEG, ECS and ECS_FF.
REQ-016 HUNT: on FF SHALL arm; when armed, D8 SHALL pulse frame_start, zero ecs_byte_cnt and go to MARK-expect; all other bytes SHALL be discarded silently.
REQ-017 MARK-expect: FF SHALL go to MARK; any other byte SHALL pulse err_sync and go to HUNT.
REQ-018 MARK, fill bytes: FF SHALL remain in MARK.
REQ-019 MARK, D9: SHALL pulse frame_done and go to HUNT.
REQ-020 MARK, D8: SHALL pulse err_sync and frame_start, then restart the frame.
REQ-021 MARK, any other marker: SHALL go to LEN_HI, recording the marker code.
REQ-022 LEN_HI/LEN_LO SHALL form a 16-bit length L; L<2 SHALL pulse err_sync and go to HUNT.
REQ-023 L=2 SHALL skip SEG and behave as at segment end.
REQ-024 SEG SHALL consume L-2 bytes using a down-counter.
REQ-025 For marker C0, SEG body offsets 1-2 SHALL form pic_height and offsets 3-4 SHALL form pic_width (MSB first).
REQ-026 pic_width and pic_height SHALL update together, with sof_ok pulsing, in the cycle after the last SEG byte; SOF0 with L<7 SHALL pulse err_sync and leave both unchanged.
REQ-027 At segment end, marker DA SHALL go to ECS; every other marker SHALL go to MARK-expect.
REQ-028 ECS: a non-FF byte SHALL be emitted; FF SHALL go to ECS_FF without output.
REQ-029 ECS_FF, 00: SHALL emit FF and return to ECS.
REQ-030 ECS_FF, D0-D7: SHALL be swallowed and return to ECS.
REQ-031 ECS_FF, FF: SHALL remain in ECS_FF.
REQ-032 ECS_FF, D9: SHALL pulse frame_done and go to HUNT.
REQ-033 ECS_FF, any other byte: SHALL be treated as a marker exactly as in MARK.
REQ-034 Emission SHALL be registered: ecs_valid/ecs_data SHALL be asserted the cycle after the accepting input cycle; all pulses SHALL have the same one-cycle latency.
REQ-035 ecs_byte_cnt SHALL increment per emitted byte and saturate at all-ones.

Reset
REQ-036 On rstn=0, state SHALL be HUNT with the FF-arm cleared, and all outputs, pic_width, pic_height, counters and the marker register SHALL be 0, independent of clk.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame with no frame_done; parsing SHALL resume at the next FF D8 after release.

Configuration
REQ-038 With JPEG_PARSE_CNT_EN defined, ecs_byte_cnt SHALL operate per REQ-035.
REQ-039 Without JPEG_PARSE_CNT_EN, ecs_byte_cnt SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-040 Bench: FF D8 FF C0 00 0B 08 00 F0 01 40 01 01 11 00 -> frame_start once; sof_ok once; pic_height=240; pic_width=320.
REQ-041 Bench: after SOS FF DA 00 02, the byte sequence 12 FF 00 34 FF D9 -> ecs outputs 12, FF, 34; frame_done one cycle after D9; ecs_byte_cnt=3 (0 without macro).
REQ-042 Bench: identical stream with data_valid toggled 1-0-0-1 throughout -> identical ecs byte sequence, pulse counts and latched values.
REQ-043 Bench: FF D8 then 55 -> err_sync pulse, state HUNT; a following FF D8 -> frame_start.
REQ-044 Bench: FF D8 FF E0 00 01 -> err_sync pulse; no sof_ok.
REQ-045 Bench: rstn low for 1 cycle during ECS -> all outputs 0; no frame_done; the next full frame parses correctly.
